// File: rtl/param_fifo_controller.sv
// Synchronous single-clock FIFO controller with occupancy count, live
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module param_fifo_controller #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH:0]   af_thresh,
  input  logic [ADDR_WIDTH:0]   ae_thresh,
  input  logic                  clear_err,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [ADDR_WIDTH-1:0] read_ptr_r;
  logic [ADDR_WIDTH-1:0] write_ptr_r;
  logic [ADDR_WIDTH:0]   count_r;
  logic [ADDR_WIDTH:0]   count_next_s;
  logic [DATA_WIDTH-1:0] data_out_r;
  logic                  data_valid_r;
  logic                  overflow_r;
  logic                  underflow_r;
  logic                  overflow_next_s;
  logic                  underflow_next_s;
  logic                  full_s;
  logic                  empty_s;
  logic                  rd_acc_s;
  logic                  wr_acc_s;

  assign empty_s  = (count_r == {(ADDR_WIDTH + 1){1'b0}});
  assign full_s   = (count_r == DEPTH_C);
  assign rd_acc_s = read_en && !empty_s;
  // A write into a full FIFO is only legal when a read frees a slot in the same cycle.
  assign wr_acc_s = write_en && (!full_s || rd_acc_s);

  // Next occupancy from the accepted read/write pair.
  always_comb begin
    count_next_s = count_r;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      2'b11:   count_next_s = count_r;
      2'b00:   count_next_s = count_r;
      default: count_next_s = count_r;
    endcase
  end

  // Sticky error flags: a fresh rejected request wins over clear_err.
  always_comb begin
    overflow_next_s  = overflow_r;
    underflow_next_s = underflow_r;
    if (write_en && !wr_acc_s) begin
      overflow_next_s = 1'b1;
    end else if (clear_err) begin
      overflow_next_s = 1'b0;
    end else begin
      overflow_next_s = overflow_r;
    end
    if (read_en && !rd_acc_s) begin
      underflow_next_s = 1'b1;
    end else if (clear_err) begin
      underflow_next_s = 1'b0;
    end else begin
      underflow_next_s = underflow_r;
    end
  end

  // Storage array; left uninitialised by reset, written only when reset is low.
  always_ff @(posedge clk) begin
    if (!reset && wr_acc_s) begin
      mem_r[write_ptr_r] <= data_in;
    end
  end

  // Pointers, occupancy, read data register and error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_ptr_r   <= {ADDR_WIDTH{1'b0}};
      write_ptr_r  <= {ADDR_WIDTH{1'b0}};
      count_r      <= {(ADDR_WIDTH + 1){1'b0}};
      data_out_r   <= {DATA_WIDTH{1'b0}};
      data_valid_r <= 1'b0;
      overflow_r   <= 1'b0;
      underflow_r  <= 1'b0;
    end else begin
      // Nonblocking read of mem_r returns the old word when the writer hits the same slot.
      if (rd_acc_s) begin
        data_out_r <= mem_r[read_ptr_r];
        read_ptr_r <= read_ptr_r + PTR_ONE;
      end
      if (wr_acc_s) begin
        write_ptr_r <= write_ptr_r + PTR_ONE;
      end
      data_valid_r <= rd_acc_s;
      count_r      <= count_next_s;
      overflow_r   <= overflow_next_s;
      underflow_r  <= underflow_next_s;
    end
  end

  assign data_out     = data_out_r;
  assign data_valid   = data_valid_r;
  assign count        = count_r;
  assign full         = full_s;
  assign empty        = empty_s;
  assign almost_full  = full_s || (count_r >= af_thresh);
  assign almost_empty = empty_s || (count_r <= ae_thresh);
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;

  param_fifo_controller_checker #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_checker (
    .clk   (clk),
    .reset (reset),
    .count (count_r),
    .full  (full_s),
    .empty (empty_s)
  );

endmodule

// Structural invariants of the occupancy counter and status flags.
module param_fifo_controller_checker #(
  parameter int ADDR_WIDTH = 4
) (
  input logic                clk,
  input logic                reset,
  input logic [ADDR_WIDTH:0] count,
  input logic                full,
  input logic                empty
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(2 ** ADDR_WIDTH);

  a_count_range : assert property (@(posedge clk) disable iff (reset) count <= DEPTH_C);
  a_full_empty  : assert property (@(posedge clk) disable iff (reset) !(full && empty));

endmodule

// File: tb/tb_param_fifo_controller.sv
// Scoreboard testbench for param_fifo_controller with default parameters.
module tb_param_fifo_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       write_en;
  logic       read_en;
  logic [7:0] data_in;
  logic [4:0] af_thresh;
  logic [4:0] ae_thresh;
  logic       clear_err;
  logic [7:0] data_out;
  logic       data_valid;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow;
  logic       underflow;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] m_last;
  logic       m_ov;
  logic       m_uf;
  logic       m_valid;

  param_fifo_controller dut (
    .clk          (clk),
    .reset        (reset),
    .write_en     (write_en),
    .read_en      (read_en),
    .data_in      (data_in),
    .af_thresh    (af_thresh),
    .ae_thresh    (ae_thresh),
    .clear_err    (clear_err),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  // One clock with the given request; model is advanced, then outputs checked.
  task automatic step(input logic we, input logic re, input logic [7:0] din, input logic clr);
    bit rd;
    bit wr;
    int n;
    rd = re && (model_q.size() > 0);
    wr = we && ((model_q.size() < 16) || rd);
    if (rd) exp_q.push_back(model_q.pop_front());
    if (wr) model_q.push_back(din);
    m_ov = (we && !wr) ? 1'b1 : (clr ? 1'b0 : m_ov);
    m_uf = (re && !rd) ? 1'b1 : (clr ? 1'b0 : m_uf);
    m_valid = rd;
    write_en = we; read_en = re; data_in = din; clear_err = clr;
    @(posedge clk);
    #1;
    write_en = 1'b0; read_en = 1'b0; clear_err = 1'b0;
    n = model_q.size();
    tests_run++;
    if (data_valid !== m_valid) begin
      tests_failed++;
      $display("FAIL data_valid: got %b expected %b", data_valid, m_valid);
    end
    if (m_valid && exp_q.size() > 0) m_last = exp_q.pop_front();
    tests_run++;
    if (data_out !== m_last) begin
      tests_failed++;
      $display("FAIL data_out: got %h expected %h", data_out, m_last);
    end
    tests_run++;
    if (count !== 5'(n) || empty !== (n == 0) || full !== (n == 16)) begin
      tests_failed++;
      $display("FAIL occupancy: got count=%0d empty=%b full=%b expected count=%0d", count, empty, full, n);
    end
    tests_run++;
    if (overflow !== m_ov || underflow !== m_uf) begin
      tests_failed++;
      $display("FAIL errors: got ov=%b uf=%b expected ov=%b uf=%b", overflow, underflow, m_ov, m_uf);
    end
  endtask

  // Reset pulse with an optional concurrent write request.
  task automatic do_reset(input logic we);
    reset = 1'b1; write_en = we; read_en = 1'b0; clear_err = 1'b0; data_in = 8'hEE;
    @(posedge clk);
    #1;
    reset = 1'b0; write_en = 1'b0;
    model_q.delete(); exp_q.delete();
    m_last = 8'h00; m_ov = 1'b0; m_uf = 1'b0; m_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    tests_run++;
    if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || data_valid !== 1'b0 ||
        data_out !== 8'h00 || overflow !== 1'b0 || underflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: got count=%0d empty=%b full=%b dv=%b dout=%h ov=%b uf=%b expected 0 1 0 0 00 0 0",
               count, empty, full, data_valid, data_out, overflow, underflow);
    end
  endtask

  task automatic test_fill_drain();
    do_reset(1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(i), 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
    tests_run++;
    if (empty !== 1'b1 || data_out !== 8'h0F) begin
      tests_failed++;
      $display("FAIL fill_drain_end: got empty=%b dout=%h expected 1 0f", empty, data_out);
    end
  endtask

  task automatic test_full_rw();
    do_reset(1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'h10 + 8'(i), 1'b0);
    step(1'b1, 1'b1, 8'hAA, 1'b0);
    tests_run++;
    if (data_out !== 8'h10 || count !== 5'd16) begin
      tests_failed++;
      $display("FAIL full_rw: got dout=%h count=%0d expected 10 16", data_out, count);
    end
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
    tests_run++;
    if (data_out !== 8'hAA) begin
      tests_failed++;
      $display("FAIL full_rw_last: got %h expected aa", data_out);
    end
  endtask

  task automatic test_overflow();
    do_reset(1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'h80 + 8'(i), 1'b0);
    step(1'b1, 1'b0, 8'h55, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    tests_run++;
    if (overflow !== 1'b1 || count !== 5'd16) begin
      tests_failed++;
      $display("FAIL overflow_sticky: got ov=%b count=%0d expected 1 16", overflow, count);
    end
    step(1'b1, 1'b0, 8'h56, 1'b1);
    tests_run++;
    if (overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL overflow_priority: got %b expected 1", overflow);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    tests_run++;
    if (overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL overflow_clear: got %b expected 0", overflow);
    end
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
  endtask

  task automatic test_underflow_empty();
    do_reset(1'b0);
    step(1'b1, 1'b1, 8'h5A, 1'b0);
    tests_run++;
    if (count !== 5'd1 || underflow !== 1'b1 || data_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL empty_rw: got count=%0d uf=%b dv=%b expected 1 1 0", count, underflow, data_valid);
    end
    step(1'b0, 1'b1, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_thresholds();
    do_reset(1'b0);
    af_thresh = 5'd12; ae_thresh = 5'd2;
    for (int n = 0; n <= 16; n++) begin
      #1;
      tests_run++;
      if (almost_empty !== (n <= 2) || almost_full !== (n >= 12)) begin
        tests_failed++;
        $display("FAIL thresh_sweep: count=%0d got ae=%b af=%b expected ae=%b af=%b",
                 n, almost_empty, almost_full, (n <= 2), (n >= 12));
      end
      if (n < 16) step(1'b1, 1'b0, 8'(n) ^ 8'hC3, 1'b0);
    end
    af_thresh = 5'd31; ae_thresh = 5'd0;
    #1;
    tests_run++;
    if (almost_full !== 1'b1 || almost_empty !== 1'b0) begin
      tests_failed++;
      $display("FAIL thresh_full_forced: got af=%b ae=%b expected 1 0", almost_full, almost_empty);
    end
    do_reset(1'b0);
    af_thresh = 5'd0; ae_thresh = 5'd16;
    step(1'b1, 1'b0, 8'h01, 1'b0);
    tests_run++;
    if (almost_full !== 1'b1 || almost_empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL thresh_extremes: got af=%b ae=%b expected 1 1", almost_full, almost_empty);
    end
    af_thresh = 5'd12; ae_thresh = 5'd2;
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 8'h20 + 8'(i), 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h77, 1'b0);
    m_ov = 1'b1;
    do_reset(1'b1);
    tests_run++;
    if (count !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0 || data_out !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_mid: got count=%0d empty=%b ov=%b uf=%b dout=%h expected 0 1 0 0 00",
               count, empty, overflow, underflow, data_out);
    end
    step(1'b1, 1'b0, 8'h3C, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    tests_run++;
    if (data_out !== 8'h3C || data_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_mid_data: got dout=%h dv=%b expected 3c 1", data_out, data_valid);
    end
  endtask

  task automatic test_back_to_back();
    do_reset(1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, (i > 2) ? 1'b1 : 1'b0, 8'($urandom_range(0, 255)), 1'b0);
    end
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
  endtask

  initial begin
    reset = 1'b1; write_en = 1'b0; read_en = 1'b0; data_in = 8'h00;
    af_thresh = 5'd12; ae_thresh = 5'd2; clear_err = 1'b0;
    m_last = 8'h00; m_ov = 1'b0; m_uf = 1'b0; m_valid = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_fill_drain();
    test_full_rw();
    test_overflow();
    test_underflow_empty();
    test_thresholds();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/param_fifo_controller.md
PARAM_FIFO_CONTROLLER -- requirements
Module: param_fifo_controller

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the data word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, the pointer width; DEPTH = 2**ADDR_WIDTH.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port write_en, input, 1 bit: write request.
REQ-006 SHALL have port read_en, input, 1 bit: read request.
REQ-007 SHALL have port data_in, input, DATA_WIDTH bits: write data.
REQ-008 SHALL have port af_thresh, input, ADDR_WIDTH+1 bits: almost-full threshold.
REQ-009 SHALL have port ae_thresh, input, ADDR_WIDTH+1 bits: almost-empty threshold.
REQ-010 SHALL have port clear_err, input, 1 bit: clears the sticky error flags.
REQ-011 SHALL have port data_out, output, DATA_WIDTH bits: registered read data.
REQ-012 SHALL have port data_valid, output, 1 bit: data_out updated this cycle.
REQ-013 SHALL have port count, output, ADDR_WIDTH+1 bits: current occupancy, 0..DEPTH.
REQ-014 SHALL have ports full, empty, almost_full and almost_empty, each output, 1 bit: status flags.
REQ-015 SHALL have ports overflow and underflow, each output, 1 bit: sticky error flags.

Function
REQ-016 SHALL define rd_acc = read_en && !empty.
REQ-017 SHALL define wr_acc = write_en && (!full || rd_acc); a write on full is accepted only together with a read.
REQ-018 SHALL, on rd_acc, register mem[read_ptr] into data_out, increment read_ptr modulo DEPTH, and pulse data_valid high for 1 cycle (1-cycle latency).
REQ-019 SHALL return the old word on a simultaneous read and write to the same address (full case).
REQ-020 SHALL, on wr_acc, write data_in to mem[write_ptr] and increment write_ptr modulo DEPTH; pointers wrap naturally with no extra logic.
REQ-021 SHALL update count as: +1 for wr_acc only, -1 for rd_acc only, unchanged for both or neither; count never exceeds DEPTH and never underflows.
REQ-022 SHALL drive the flags combinationally from count: empty = (count==0); full = (count==DEPTH); almost_full = (count >= af_thresh), asserted while full; almost_empty = (count <= ae_thresh), asserted while empty.
REQ-023 SHALL use thresholds live, with no latching; af_thresh=0 forces almost_full high, and ae_thresh >= DEPTH forces almost_empty high.
REQ-024 SHALL set overflow on write_en && !wr_acc and set underflow on read_en && !rd_acc; both hold until clear_err or reset.
REQ-025 SHALL give priority to a new error event over clear_err in the same cycle, so the flag stays set.
REQ-026 SHALL hold data_out when no read is accepted.

Reset
REQ-027 SHALL, when reset is high at a clock edge, set read_ptr, write_ptr, count, data_out, data_valid, overflow and underflow to 0, giving empty=1 and full=0.
REQ-028 SHALL have reset override any concurrent write_en, read_en or clear_err, ignore in-flight operations, and leave memory contents uninitialised; reset is allowed mid-operation.

Verification
REQ-029 SHALL cover: with defaults, 16 writes 0x00..0x0F, then 16 reads -> data_out 0x00..0x0F in order, each with data_valid 1 cycle after read_en, and empty=1 at the end.
REQ-030 SHALL cover: full, then write_en=1 with read_en=1, data_in=0xAA -> data_out=oldest word, count stays 16, and 0xAA is read out last.
REQ-031 SHALL cover: full, then write_en only -> count stays 16, overflow=1 and stays 1; clear_err -> overflow=0 the next cycle.
REQ-032 SHALL cover: empty with write_en=1 and read_en=1 -> write accepted, read rejected, count=1, underflow=1, data_valid=0.
REQ-033 SHALL cover: af_thresh=12, ae_thresh=2, sweep count 0..16 -> almost_empty for count 0..2 and almost_full for count 12..16.
REQ-034 SHALL cover: reset asserted at count=9 with write_en=1 -> count=0, empty=1, error flags 0, and next write then read returns the new data.
